// File: rtl/circuit_sweep.sv
// Stimulus-and-capture stage for a 4-input combinational block.
// Sweeps {A,B,C,D} through all 16 vectors, samples F and compares it with a golden table.
module circuit_sweep #(
  parameter logic [7:0]  SETTLE   = 8'd1,
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        F,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] truth_table,  // captured table; "table" is a reserved word
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  mismatch_idx
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [3:0]  abcd_q, abcd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [15:0] tbl_q, tbl_d;
  logic [4:0]  mcnt_q, mcnt_d;
  logic [3:0]  midx_q, midx_d;
  logic        miss;

  assign miss = (F != EXPECTED[idx_q]);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wait_cnt_d = wait_cnt_q;
    pass_d     = pass_q;
    tbl_d      = tbl_q;
    mcnt_d     = mcnt_q;
    midx_d     = midx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d      = 4'd0;
          wait_cnt_d = SETTLE;
          tbl_d      = 16'h0000;
          mcnt_d     = 5'd0;
          midx_d     = 4'd0;
          pass_d     = 1'b0;
          state_d    = (SETTLE != 8'd0) ? S_SETTLE : S_SAMPLE;
        end
      end
      S_SETTLE: begin
        wait_cnt_d = wait_cnt_q - 8'd1;
        if (wait_cnt_q <= 8'd1) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        tbl_d[idx_q] = F;
        if (miss) begin
          mcnt_d = mcnt_q + 5'd1;
          if (mcnt_q == 5'd0) midx_d = idx_q;
        end
        if (idx_q == 4'd15) begin
          state_d = S_DONE;
          pass_d  = (mcnt_d == 5'd0);
        end else begin
          idx_d      = idx_q + 4'd1;
          wait_cnt_d = SETTLE;
          state_d    = (SETTLE != 8'd0) ? S_SETTLE : S_SAMPLE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Outputs are decoded from the next state so they come straight from flops.
    busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
    abcd_d = busy_d ? idx_d : 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      wait_cnt_q <= 8'd0;
      abcd_q     <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      tbl_q      <= 16'h0000;
      mcnt_q     <= 5'd0;
      midx_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wait_cnt_q <= wait_cnt_d;
      abcd_q     <= abcd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      tbl_q      <= tbl_d;
      mcnt_q     <= mcnt_d;
      midx_q     <= midx_d;
    end
  end

  assign {A, B, C, D}   = abcd_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign truth_table    = tbl_q;
  assign mismatch_cnt   = mcnt_q;
  assign mismatch_idx   = midx_q;

endmodule

// File: tb/tb_circuit_sweep.sv
// Directed bench for circuit_sweep: three instances with settle times 1, 0 and 3.
module tb_circuit_sweep;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instance 1: SETTLE=1, F = A&B (or tied 0)
  logic start1 = 1'b0, f1_zero = 1'b0, F1;
  logic A1, B1, C1, D1, busy1, done1, pass1;
  logic [15:0] tbl1; logic [4:0] mcnt1; logic [3:0] midx1;
  assign F1 = f1_zero ? 1'b0 : (A1 & B1);
  circuit_sweep #(.SETTLE(8'd1), .EXPECTED(16'hF000)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .F(F1),
    .A(A1), .B(B1), .C(C1), .D(D1), .busy(busy1), .done(done1), .pass(pass1),
    .truth_table(tbl1), .mismatch_cnt(mcnt1), .mismatch_idx(midx1));

  // Instance 0: SETTLE=0, F = A^D
  logic start0 = 1'b0, F0;
  logic A0, B0, C0, D0, busy0, done0, pass0;
  logic [15:0] tbl0; logic [4:0] mcnt0; logic [3:0] midx0;
  assign F0 = A0 ^ D0;
  circuit_sweep #(.SETTLE(8'd0), .EXPECTED(16'h5AA5)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .F(F0),
    .A(A0), .B(B0), .C(C0), .D(D0), .busy(busy0), .done(done0), .pass(pass0),
    .truth_table(tbl0), .mismatch_cnt(mcnt0), .mismatch_idx(midx0));

  // Instance 3: SETTLE=3, F = ~(A^B^D) but only settles 3 cycles after each vector change
  logic start3 = 1'b0, F3 = 1'b1;
  logic A3, B3, C3, D3, busy3, done3, pass3;
  logic [15:0] tbl3; logic [4:0] mcnt3; logic [3:0] midx3;
  circuit_sweep #(.SETTLE(8'd3), .EXPECTED(16'h5AA5)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .F(F3),
    .A(A3), .B(B3), .C(C3), .D(D3), .busy(busy3), .done(done3), .pass(pass3),
    .truth_table(tbl3), .mismatch_cnt(mcnt3), .mismatch_idx(midx3));

  logic [3:0] last3 = 4'd0;
  int age3 = 0;
  int runs3 = 0;
  always @(posedge clk) begin
    #1;
    if ({A3, B3, C3, D3} != last3) begin
      if (last3 != 4'd0) begin
        chk("run_len_s3", age3 + 1, 4);
        runs3++;
      end
      last3 = {A3, B3, C3, D3};
      age3  = 0;
      F3    = A3 ^ B3 ^ D3;  // wrong value until settled
    end else begin
      age3++;
      if (age3 == 3) F3 = ~(A3 ^ B3 ^ D3);
    end
  end

  function automatic logic sel_done(input int which);
    case (which)
      0:       return done0;
      1:       return done1;
      default: return done3;
    endcase
  endfunction

  // Returns the edge count (from the start edge) at which done was first seen.
  task automatic wait_done(input int which, input int n0, output int n);
    n = n0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (sel_done(which)) break;
    end
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      0: start0 = 1'b1;
      1: start1 = 1'b1;
      default: start3 = 1'b1;
    endcase
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0; start3 = 1'b0;
  endtask

  initial begin
    int n;
    logic seen;
    #12;
    chk("rst_abcd", {A1, B1, C1, D1}, 4'd0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_done", done1, 1'b0);
    chk("rst_pass", pass1, 1'b0);
    chk("rst_table", tbl1, 16'h0000);
    chk("rst_cnt", {midx1, mcnt1}, 9'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // A&B against F000
    pulse(1);
    chk("busy_rise", busy1, 1'b1);
    wait_done(1, 0, n);
    chk("t1_latency", n, 32);
    chk("t1_busy_at_done", busy1, 1'b0);
    chk("t1_table", tbl1, 16'hF000);
    chk("t1_pass", pass1, 1'b1);
    chk("t1_cnt", mcnt1, 5'd0);
    chk("t1_idx", midx1, 4'd0);
    @(negedge clk);
    chk("t1_done_one_cycle", done1, 1'b0);
    chk("t1_table_hold", tbl1, 16'hF000);

    // F tied 0
    f1_zero = 1'b1;
    pulse(1);
    wait_done(1, 0, n);
    chk("t2_latency", n, 32);
    chk("t2_table", tbl1, 16'h0000);
    chk("t2_cnt", mcnt1, 5'd4);
    chk("t2_idx", midx1, 4'd12);
    chk("t2_pass", pass1, 1'b0);
    f1_zero = 1'b0;

    // SETTLE=0: A^D gives table 55AA, 8 bits differ from 5AA5, first at index 0
    pulse(0);
    chk("t3_vec0", {A0, B0, C0, D0}, 4'd0);
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("t3_vec%0d", k), {A0, B0, C0, D0}, k[3:0]);
    end
    @(negedge clk);
    chk("t3_done_at_16", done0, 1'b1);
    chk("t3_abcd_done", {A0, B0, C0, D0}, 4'd0);
    chk("t3_table", tbl0, 16'h55AA);
    chk("t3_cnt", mcnt0, 5'd8);
    chk("t3_idx", midx0, 4'd0);
    chk("t3_pass", pass0, 1'b0);

    // start while busy at vector 5 is ignored
    pulse(1);
    n = 0;
    while (n < 100 && {A1, B1, C1, D1} != 4'd5) begin
      @(negedge clk); n++;
    end
    chk("t4_vec5_edge", n, 10);
    start1 = 1'b1;
    @(negedge clk); n++;
    start1 = 1'b0;
    wait_done(1, n, n);
    chk("t4_latency", n, 32);
    chk("t4_pass", pass1, 1'b1);
    pulse(1);
    chk("t4_restart_clears_table", tbl1, 16'h0000);
    chk("t4_restart_clears_pass", pass1, 1'b0);
    wait_done(1, 0, n);
    chk("t4_rerun_latency", n, 32);
    chk("t4_rerun_table", tbl1, 16'hF000);

    // async reset at vector 9
    pulse(1);
    n = 0;
    while (n < 100 && {A1, B1, C1, D1} != 4'd9) begin
      @(negedge clk); n++;
    end
    chk("t5_vec9_edge", n, 18);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_abcd", {A1, B1, C1, D1}, 4'd0);
    chk("t5_busy", busy1, 1'b0);
    chk("t5_table", tbl1, 16'h0000);
    chk("t5_pass_done", {pass1, done1}, 2'b00);
    seen = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      seen = seen | done1 | busy1;
    end
    chk("t5_no_done_after_abort", seen, 1'b0);
    pulse(1);
    wait_done(1, 0, n);
    chk("t5_fresh_latency", n, 32);
    chk("t5_fresh_table", tbl1, 16'hF000);
    chk("t5_fresh_pass", pass1, 1'b1);

    // SETTLE=3 with a slow-settling F
    pulse(3);
    wait_done(3, 0, n);
    chk("t6_latency", n, 64);
    chk("t6_table", tbl3, 16'h5AA5);
    chk("t6_pass", pass3, 1'b1);
    chk("t6_cnt", mcnt3, 5'd0);
    @(negedge clk);
    chk("t6_runs_checked", runs3, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
